// File: rtl/vga_timing_gen.sv
// vga_timing_gen
//   Pixel-rate VGA raster timing generated from a faster board clock.
//   A divider produces one pixel period every DIV clocks; horizontal and
//   vertical counters step on the last clock of each pixel period. Every
//   output comes straight from a flop. Sync and blanking flags are
//   registered from the next-state counters, so they line up with the
//   counters presented in the same cycle.
//
// Ports
//   clk_i          board clock, rising-edge active
//   rst_i          asynchronous active-high reset
//   hcount_o[9:0]  current pixel column, 0..H_TOTAL-1
//   vcount_o[9:0]  current line, 0..V_TOTAL-1
//   hsync_o        horizontal sync, active low while hcount < H_SYNC
//   vsync_o        vertical sync, active low while vcount < V_SYNC
//   bright_o       high inside the visible window
//   pix_tick_o     high on the last clock of each pixel period
//   frame_start_o  one-clock pulse on the first clock of pixel (0,0)
module vga_timing_gen #(
    parameter int DIV            = 4,
    parameter int H_TOTAL        = 800,
    parameter int H_SYNC         = 96,
    parameter int H_BRIGHT_START = 144,
    parameter int H_BRIGHT_END   = 784,
    parameter int V_TOTAL        = 525,
    parameter int V_SYNC         = 2,
    parameter int V_BRIGHT_START = 35,
    parameter int V_BRIGHT_END   = 515
) (
    input  logic       clk_i,
    input  logic       rst_i,
    output logic [9:0] hcount_o,
    output logic [9:0] vcount_o,
    output logic       hsync_o,
    output logic       vsync_o,
    output logic       bright_o,
    output logic       pix_tick_o,
    output logic       frame_start_o
);

    localparam int DW = (DIV > 2) ? $clog2(DIV) : 1;

    localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
    localparam logic [9:0]    H_LAST   = 10'(H_TOTAL - 1);
    localparam logic [9:0]    V_LAST   = 10'(V_TOTAL - 1);
    localparam logic [9:0]    H_SYNC_W = 10'(H_SYNC);
    localparam logic [9:0]    V_SYNC_W = 10'(V_SYNC);
    localparam logic [9:0]    H_BS     = 10'(H_BRIGHT_START);
    localparam logic [9:0]    H_BE     = 10'(H_BRIGHT_END);
    localparam logic [9:0]    V_BS     = 10'(V_BRIGHT_START);
    localparam logic [9:0]    V_BE     = 10'(V_BRIGHT_END);

    logic [DW-1:0] div_q, div_d;
    logic [9:0]    h_q, h_d;
    logic [9:0]    v_q, v_d;
    logic          hsync_q, hsync_d;
    logic          vsync_q, vsync_d;
    logic          bright_q, bright_d;
    logic          tick_q, tick_d;
    logic          fs_q, fs_d;
    logic          last_clk;

    always_comb begin
        last_clk = (div_q == DIV_LAST);
        div_d    = last_clk ? '0 : div_q + 1'b1;
        h_d      = h_q;
        v_d      = v_q;
        if (last_clk) begin
            if (h_q == H_LAST) begin
                h_d = '0;
                v_d = (v_q == V_LAST) ? '0 : v_q + 10'd1;
            end else begin
                h_d = h_q + 10'd1;
            end
        end

        // Flags follow the counter values that will be visible next cycle.
        hsync_d  = (h_d >= H_SYNC_W);
        vsync_d  = (v_d >= V_SYNC_W);
        bright_d = (h_d >= H_BS) && (h_d < H_BE) && (v_d >= V_BS) && (v_d < V_BE);
        tick_d   = (div_d == DIV_LAST);
        // Only a genuine wrap out of the last pixel raises frame_start, so
        // the (0,0) seen after reset release never does.
        fs_d     = last_clk && (h_q == H_LAST) && (v_q == V_LAST);
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            div_q    <= '0;
            h_q      <= '0;
            v_q      <= '0;
            hsync_q  <= 1'b0;
            vsync_q  <= 1'b0;
            bright_q <= 1'b0;
            tick_q   <= 1'b0;
            fs_q     <= 1'b0;
        end else begin
            div_q    <= div_d;
            h_q      <= h_d;
            v_q      <= v_d;
            hsync_q  <= hsync_d;
            vsync_q  <= vsync_d;
            bright_q <= bright_d;
            tick_q   <= tick_d;
            fs_q     <= fs_d;
        end
    end

    assign hcount_o      = h_q;
    assign vcount_o      = v_q;
    assign hsync_o       = hsync_q;
    assign vsync_o       = vsync_q;
    assign bright_o      = bright_q;
    assign pix_tick_o    = tick_q;
    assign frame_start_o = fs_q;

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb_vga_timing_gen
//   Runs a reduced-size raster so whole frames fit in a short simulation.
//   The reference derives every output from the number of clock edges since
//   reset release using plain division and modulo on the raster geometry.
module tb_vga_timing_gen;

    localparam int DIV   = 4;
    localparam int HT    = 20;
    localparam int HS    = 3;
    localparam int HBS   = 5;
    localparam int HBE   = 17;
    localparam int VT    = 12;
    localparam int VS    = 2;
    localparam int VBS   = 3;
    localparam int VBE   = 10;
    localparam int FRAME = HT * VT * DIV;

    logic       clk;
    logic       rst;
    logic [9:0] hcount, vcount;
    logic       hsync, vsync, bright, pix_tick, frame_start;

    int vectors     = 0;
    int miscompares = 0;
    int t           = 0;
    int bright_cnt  = 0;
    int fs_cnt      = 0;

    vga_timing_gen #(
        .DIV(DIV), .H_TOTAL(HT), .H_SYNC(HS),
        .H_BRIGHT_START(HBS), .H_BRIGHT_END(HBE),
        .V_TOTAL(VT), .V_SYNC(VS),
        .V_BRIGHT_START(VBS), .V_BRIGHT_END(VBE)
    ) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .hcount_o     (hcount),
        .vcount_o     (vcount),
        .hsync_o      (hsync),
        .vsync_o      (vsync),
        .bright_o     (bright),
        .pix_tick_o   (pix_tick),
        .frame_start_o(frame_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s t=%0d observed=%0d expected=%0d", tag, t, obs, exp);
        end
    endtask

    // Expected outputs for the cycle following edge number t since release.
    task automatic check_all();
        int p, eh, ev;
        logic etick, efs, ehs, evs, ebr;
        p     = t / DIV;
        eh    = p % HT;
        ev    = (p / HT) % VT;
        etick = (t % DIV) == DIV - 1;
        efs   = (t > 0) && (t % FRAME == 0);
        ehs   = eh >= HS;
        evs   = ev >= VS;
        ebr   = (eh >= HBS) && (eh < HBE) && (ev >= VBS) && (ev < VBE);
        chk("hcount",      32'(hcount),      32'(eh));
        chk("vcount",      32'(vcount),      32'(ev));
        chk("hsync",       32'(hsync),       32'(ehs));
        chk("vsync",       32'(vsync),       32'(evs));
        chk("bright",      32'(bright),      32'(ebr));
        chk("pix_tick",    32'(pix_tick),    32'(etick));
        chk("frame_start", 32'(frame_start), 32'(efs));
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            if (!rst) t++;
            @(negedge clk);
            check_all();
            if (bright) bright_cnt++;
            if (frame_start) fs_cnt++;
        end
    endtask

    // Reset is raised between edges and the outputs are checked before the
    // next edge arrives; release happens on a falling edge.
    task automatic async_reset(input int hold);
        #2 rst = 1'b1;
        t = 0;
        #1 check_all();
        run(hold);
        rst = 1'b0;
        check_all();
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(negedge clk);
        t = 0;
        check_all();
        rst = 1'b0;
        check_all();

        // Two full frames straight from reset release.
        bright_cnt = 0;
        fs_cnt     = 0;
        run(2 * FRAME);
        chk("bright_cycles_2frames", 32'(bright_cnt), 32'(2 * (HBE - HBS) * (VBE - VBS) * DIV));
        chk("frame_start_2frames",   32'(fs_cnt),     32'(2));

        // Reset in the middle of a line, mid-frame, then restart.
        async_reset(2);
        run((6 * HT + 10) * DIV + 2);
        chk("pos_h_before_rst", 32'(hcount), 32'(10));
        chk("pos_v_before_rst", 32'(vcount), 32'(6));
        async_reset(1);
        run(FRAME + 8);

        // Randomized run lengths and reset hold times.
        for (int k = 0; k < 8; k++) begin
            run($urandom_range(1, 1500));
            async_reset($urandom_range(0, 3));
        end
        run(FRAME + 5);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/vga_timing_gen.md
VGA_TIMING_GEN -- requirements
Module: vga_timing_gen

Interface
REQ-001 Parameter DIV, default 4: board-clock cycles per pixel (25 MHz pixels from 100 MHz clk); legal values 2..16.
REQ-002 Parameter H_TOTAL, default 800: pixels per line, hCount range 0..H_TOTAL-1.
REQ-003 Parameter H_SYNC, default 96: hSync low while hCount < H_SYNC.
REQ-004 Parameters H_BRIGHT_START, default 144, and H_BRIGHT_END, default 784: visible columns are H_BRIGHT_START <= hCount < H_BRIGHT_END.
REQ-005 Parameter V_TOTAL, default 525: lines per frame, vCount range 0..V_TOTAL-1.
REQ-006 Parameter V_SYNC, default 2: vSync low while vCount < V_SYNC.
REQ-007 Parameters V_BRIGHT_START, default 35, and V_BRIGHT_END, default 515: visible lines are V_BRIGHT_START <= vCount < V_BRIGHT_END.
REQ-008 clk  input  1  board clock; single clock domain; all state updates on its rising edge.
REQ-009 rst  input  1  asynchronous, active-high reset.
REQ-010 hCount  output  10  current pixel column, registered.
REQ-011 vCount  output  10  current line, registered.
REQ-012 hSync  output  1  horizontal sync, active low, registered.
REQ-013 vSync  output  1  vertical sync, active low, registered.
REQ-014 bright  output  1  high only inside the visible window, registered.
REQ-015 pix_tick  output  1  one-clk pulse marking the last clk of each pixel period.
REQ-016 frame_start  output  1  one-clk pulse on the first clk of pixel (0,0).

Function
REQ-017 Divider counter div SHALL count 0..DIV-1 and wrap to 0; pix_tick SHALL be high exactly in cycles where div == DIV-1.
REQ-018 hCount SHALL change only on the clk edge ending a pix_tick cycle: +1, or wrap H_TOTAL-1 -> 0.
REQ-019 vCount SHALL increment only on the edge where hCount wraps; at V_TOTAL-1 with hCount wrap, vCount SHALL wrap to 0.
REQ-020 hSync, vSync, bright SHALL be computed from next-state counter values and registered, so in every cycle they correspond exactly to the hCount/vCount presented in that cycle (zero skew, hold constant for all DIV clks of a pixel).
REQ-021 bright SHALL equal (hCount in visible columns) AND (vCount in visible lines); never high outside either window.
REQ-022 frame_start SHALL be high for exactly one clk, the cycle after the edge moving (H_TOTAL-1, V_TOTAL-1) -> (0,0); never at any other point, including immediately after reset release.
REQ-023 Counter arithmetic SHALL be unsigned 10-bit; no value >= H_TOTAL or >= V_TOTAL SHALL ever appear on hCount/vCount.
REQ-024 Line period SHALL be H_TOTAL*DIV clks; frame period SHALL be H_TOTAL*V_TOTAL*DIV clks, with no dropped or repeated pixels.
REQ-025 Downstream sprite/ROM controllers SHALL be able to sample hCount/vCount/bright on any clk edge; outputs SHALL be glitch-free (driven directly from flops).

Reset
REQ-026 While rst is high, asynchronously and without a clk edge: div=0, hCount=0, vCount=0, hSync=0, vSync=0, bright=0, pix_tick=0, frame_start=0.
REQ-027 hSync=0 and vSync=0 at reset SHALL be consistent with REQ-020 for position (0,0).
REQ-028 After rst deasserts, the first rising edge SHALL set div=1; counting resumes from (0,0) without emitting frame_start.
REQ-029 Reset asserted mid-line or mid-frame SHALL abandon the frame; no partial pulses SHALL persist.

Verification
REQ-030 Reset release, DIV=4 -> pix_tick high on 3rd clk after release, then every 4 clks; hCount=1 after 4th edge.
REQ-031 Run one line -> hSync low for hCount 0..95 (384 clks), high for 96..799; after hCount 799, hCount=0 and vCount=1 on the same edge.
REQ-032 Scan a full frame -> bright high exactly for hCount 144..783 with vCount 35..514; 640x480 = 307200 visible pixels counted.
REQ-033 Frame wrap -> (799,524) to (0,0), frame_start exactly one clk; vSync low only for vCount 0..1; frame period 1,680,000 clks.
REQ-034 Assert rst asynchronously at hCount=400, vCount=200, between clk edges -> all outputs reach reset values before the next edge; restart per REQ-028.
REQ-035 Per-cycle checker over two frames -> hSync/vSync/bright always match REQ-003..007 against hCount/vCount in the same cycle.
